// File: rtl/lfsr_decrypt_engine_if.sv
// lfsr_decrypt_engine_if: byte-wide data-memory bus between the decrypt engine and its memory
// Ports (signals):
//   MemAddr   - byte address driven by the engine
//   MemRdEn   - read strobe; MemRdData answers one cycle later
//   MemRdData - read data returned by the memory
//   MemWrEn   - write enable, committed by the memory at the clock edge
//   MemWrData - write data driven by the engine
// Modports: master = engine side, slave = memory side.
interface lfsr_decrypt_engine_if;
    logic [7:0] MemAddr;
    logic       MemRdEn;
    logic [7:0] MemRdData;
    logic       MemWrEn;
    logic [7:0] MemWrData;
    modport master (output MemAddr, MemRdEn, MemWrEn, MemWrData, input MemRdData);
    modport slave  (input MemAddr, MemRdEn, MemWrEn, MemWrData, output MemRdData);
endinterface

// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine: decrypts a ciphertext buffer into a plaintext buffer with a 7-bit LFSR keystream
// Ports:
//   Clk       - clock, all state updates on its rising edge
//   Reset     - asynchronous active-low reset
//   Start     - level request; accepted only in IDLE or DONE
//   Ack       - high while in DONE, until the next accepted Start
//   Busy      - high while a message is being processed (RD/WR)
//   TapPtrn   - LFSR feedback tap mask, latched on accept
//   Seed      - initial LFSR state, latched on accept
//   SrcBase   - ciphertext start address, latched on accept
//   DstBase   - plaintext start address, latched on accept
//   Length    - byte count (0 legal), latched on accept
//   ParityErr - sticky flag: a ciphertext byte had odd 8-bit parity
//   mem       - data-memory bus (master side)
module lfsr_decrypt_engine #(
    parameter int LEN_W = 6
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    output logic                  Ack,
    output logic                  Busy,
    input  logic [6:0]            TapPtrn,
    input  logic [6:0]            Seed,
    input  logic [7:0]            SrcBase,
    input  logic [7:0]            DstBase,
    input  logic [LEN_W-1:0]      Length,
    output logic                  ParityErr,
    lfsr_decrypt_engine_if.master mem
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             st, st_nx;
    logic [6:0]         tap, key;
    logic [7:0]         src, dst;
    logic [LEN_W-1:0]   len, idx, idx_inc;
    logic               accept;

    assign idx_inc = idx + LEN_W'(1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) st <= IDLE;
        else        st <= st_nx;
    end

    // Outputs decode purely from the state so that reset zeroes them immediately.
    always_comb begin
        st_nx         = st;
        accept        = 1'b0;
        Ack           = 1'b0;
        Busy          = 1'b0;
        mem.MemRdEn   = 1'b0;
        mem.MemWrEn   = 1'b0;
        mem.MemAddr   = 8'h00;
        mem.MemWrData = 8'h00;
        case (st)
            IDLE, DONE: begin
                Ack = (st == DONE);
                if (Start) begin
                    accept = 1'b1;
                    st_nx  = (Length == '0) ? DONE : RD;
                end
            end
            RD: begin
                Busy        = 1'b1;
                mem.MemRdEn = 1'b1;
                mem.MemAddr = src + 8'(idx);
                st_nx       = WR;
            end
            default: begin
                Busy          = 1'b1;
                mem.MemWrEn   = 1'b1;
                mem.MemAddr   = dst + 8'(idx);
                mem.MemWrData = {1'b0, mem.MemRdData[6:0] ^ key};
                st_nx         = (idx_inc == len) ? DONE : RD;
            end
        endcase
    end

    // Every exit from WR consumes one byte: advance the keystream and the index.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tap       <= '0;
            key       <= '0;
            src       <= '0;
            dst       <= '0;
            len       <= '0;
            idx       <= '0;
            ParityErr <= 1'b0;
        end else if (accept) begin
            tap       <= TapPtrn;
            key       <= Seed;
            src       <= SrcBase;
            dst       <= DstBase;
            len       <= Length;
            idx       <= '0;
            ParityErr <= 1'b0;
        end else if (st == WR) begin
            key       <= {key[5:0], ^(key & tap)};
            idx       <= idx_inc;
            ParityErr <= ParityErr | (^mem.MemRdData);
        end
    end
endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// tb_lfsr_decrypt_engine: scoreboard bench for the LFSR decrypt engine with a synchronous memory model
module tb_lfsr_decrypt_engine;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Ack, Busy, ParityErr;
    logic [6:0] TapPtrn = '0;
    logic [6:0] Seed = '0;
    logic [7:0] SrcBase = '0;
    logic [7:0] DstBase = '0;
    logic [5:0] Length = '0;

    lfsr_decrypt_engine_if bus();

    lfsr_decrypt_engine #(.LEN_W(6)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Busy(Busy),
        .TapPtrn(TapPtrn), .Seed(Seed), .SrcBase(SrcBase), .DstBase(DstBase),
        .Length(Length), .ParityErr(ParityErr), .mem(bus.master)
    );

    always #5 Clk = ~Clk;

    logic [7:0]  mem [256];
    logic [7:0]  rd_q [$];
    logic [15:0] wr_q [$];
    logic [15:0] wr_e;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge Clk) begin
        if (bus.MemRdEn) bus.MemRdData <= mem[bus.MemAddr];
        if (bus.MemWrEn) mem[bus.MemAddr] <= bus.MemWrData;
    end

    always @(negedge Clk) begin
        if (bus.MemRdEn || bus.MemWrEn) check("rd_wr_excl", 32'(bus.MemRdEn & bus.MemWrEn), 32'd0);
        if (bus.MemRdEn) begin
            check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) check("rd_addr", 32'(bus.MemAddr), 32'(rd_q.pop_front()));
        end
        if (bus.MemWrEn) begin
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 32'(bus.MemAddr), 32'(wr_e[15:8]));
                check("wr_data", 32'(bus.MemWrData), 32'(wr_e[7:0]));
            end
        end
    end

    // Reference model: walks a private memory copy so overlapping src/dst regions see earlier writes.
    task automatic push_msg(input logic [6:0] tap, input logic [6:0] seed, input logic [7:0] src,
                            input logic [7:0] dst, input logic [5:0] len, output logic ep);
        logic [7:0] m [256];
        logic [6:0] k;
        logic [7:0] c, ra, wa;
        m  = mem;
        k  = seed;
        ep = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            ra = src + 8'(i);
            wa = dst + 8'(i);
            c  = m[ra];
            rd_q.push_back(ra);
            wr_q.push_back({wa, 1'b0, c[6:0] ^ k});
            m[wa] = {1'b0, c[6:0] ^ k};
            ep = ep | (^c);
            k  = {k[5:0], ^(k & tap)};
        end
    endtask

    task automatic run_msg(input logic [6:0] tap, input logic [6:0] seed, input logic [7:0] src,
                           input logic [7:0] dst, input logic [5:0] len, input bit toggle);
        logic ep;
        int   cnt;
        bit   busy_seen;
        TapPtrn = tap; Seed = seed; SrcBase = src; DstBase = dst; Length = len;
        push_msg(tap, seed, src, dst, len, ep);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check("par_clear", 32'(ParityErr), 32'd0);
        TapPtrn = 7'($urandom); Seed = 7'($urandom);
        SrcBase = 8'($urandom); DstBase = 8'($urandom); Length = 6'($urandom);
        cnt = 1;
        busy_seen = Busy;
        while (!Ack && cnt < 200) begin
            if (Busy && toggle) Start = 1'($urandom);
            @(posedge Clk);
            cnt++;
            #1;
            busy_seen |= Busy;
        end
        Start = 1'b0;
        check("ack_latency", 32'(cnt), 32'(2 * int'(len) + 1));
        check("busy_seen", 32'(busy_seen), 32'(len != 0));
        check("parity_err", 32'(ParityErr), 32'(ep));
        check("rd_drained", 32'(rd_q.size()), 32'd0);
        check("wr_drained", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic ep;
        int   cnt;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (2) @(posedge Clk);
        #1;
        check("rst_ack", 32'(Ack), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_rden", 32'(bus.MemRdEn), 32'd0);
        check("rst_wren", 32'(bus.MemWrEn), 32'd0);
        check("rst_addr", 32'(bus.MemAddr), 32'd0);
        check("rst_wdata", 32'(bus.MemWrData), 32'd0);
        check("rst_par", 32'(ParityErr), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        mem[8'h40] = 8'hC9;
        run_msg(7'h60, 7'h01, 8'h40, 8'h80, 6'd1, 1'b0);
        check("known_vector", 32'(mem[8'h80]), 32'h48);
        @(posedge Clk);
        #1;
        check("ack_held", 32'(Ack), 32'd1);

        run_msg(7'h60, 7'h01, 8'h10, 8'h20, 6'd0, 1'b0);

        run_msg(7'h60, 7'h01, 8'hFE, 8'hFF, 6'd4, 1'b0);

        mem[8'h10] = 8'h49;
        run_msg(7'h60, 7'h05, 8'h10, 8'h30, 6'd1, 1'b0);
        mem[8'h11] = 8'h03;
        run_msg(7'h60, 7'h05, 8'h11, 8'h31, 6'd1, 1'b0);

        run_msg(7'h41, 7'h00, 8'h50, 8'h60, 6'd3, 1'b0);

        run_msg(7'h5A, 7'h33, 8'h90, 8'hA0, 6'd10, 1'b1);

        for (int i = 0; i < 5; i++) mem[8'hC0 + 8'(i)] = 8'hEE;
        TapPtrn = 7'h60; Seed = 7'h2B; SrcBase = 8'hB0; DstBase = 8'hC0; Length = 6'd5;
        push_msg(7'h60, 7'h2B, 8'hB0, 8'hC0, 6'd5, ep);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("mid_wr_state", 32'(bus.MemWrEn), 32'd1);
        Reset = 1'b0;
        #1;
        check("abort_wren", 32'(bus.MemWrEn), 32'd0);
        check("abort_addr", 32'(bus.MemAddr), 32'd0);
        check("abort_wdata", 32'(bus.MemWrData), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_pending", 32'(wr_q.size()), 32'd4);
        @(negedge Clk);
        Reset = 1'b1;
        check("abort_no_write", 32'(mem[8'hC1]), 32'hEE);
        rd_q.delete();
        wr_q.delete();
        repeat (2) @(posedge Clk);
        #1;
        check("idle_after_rst", 32'(Busy | Ack), 32'd0);
        run_msg(7'h60, 7'h2B, 8'hB0, 8'hC0, 6'd5, 1'b0);

        TapPtrn = 7'h60; Seed = 7'h11; SrcBase = 8'h08; DstBase = 8'hD0; Length = 6'd2;
        push_msg(7'h60, 7'h11, 8'h08, 8'hD0, 6'd2, ep);
        push_msg(7'h60, 7'h11, 8'h08, 8'hD0, 6'd2, ep);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        cnt = 1;
        while (!Ack && cnt < 50) begin
            @(posedge Clk);
            cnt++;
            #1;
        end
        check("held_lat1", 32'(cnt), 32'd5);
        @(posedge Clk);
        #1;
        check("done_one_cycle", 32'(Ack), 32'd0);
        check("restart_busy", 32'(Busy), 32'd1);
        Start = 1'b0;
        cnt = 1;
        while (!Ack && cnt < 50) begin
            @(posedge Clk);
            cnt++;
            #1;
        end
        check("held_lat2", 32'(cnt), 32'd5);
        check("held_drained", 32'(wr_q.size()), 32'd0);

        run_msg(7'h7F, 7'h55, 8'h00, 8'h80, 6'd63, 1'b1);
        for (int n = 0; n < 4; n++)
            run_msg(7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 6'($urandom_range(1, 20)), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr_decrypt_engine.md
LFSR_DECRYPT_ENGINE -- requirements
Module: lfsr_decrypt_engine

Interface
REQ-001 SHALL have parameter LEN_W, default 6, giving the message-length field width (maximum message 2^LEN_W-1 bytes).
REQ-002 SHALL have port Clk, input, 1, the single clock; all state is updated on posedge Clk.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Start, input, 1, level request to begin decryption.
REQ-005 SHALL have port Ack, output, 1, done flag.
REQ-006 SHALL have port Busy, output, 1, high while a message is being processed.
REQ-007 SHALL have port TapPtrn, input, 7, LFSR feedback tap mask.
REQ-008 SHALL have port Seed, input, 7, initial LFSR state.
REQ-009 SHALL have port SrcBase, input, 8, ciphertext start address.
REQ-010 SHALL have port DstBase, input, 8, plaintext start address.
REQ-011 SHALL have port Length, input, LEN_W, byte count, 0 legal.
REQ-012 SHALL have port MemAddr, output, 8, data-memory address.
REQ-013 SHALL have port MemRdEn, output, 1, read strobe; MemRdData is valid the following cycle.
REQ-014 SHALL have port MemRdData, input, 8, read data.
REQ-015 SHALL have port MemWrEn, output, 1, write enable, committed at posedge Clk.
REQ-016 SHALL have port MemWrData, output, 8, write data.
REQ-017 SHALL have port ParityErr, output, 1, sticky flag for a ciphertext byte with odd 8-bit parity.

Function
REQ-018 SHALL implement states IDLE, RD, WR, DONE.
REQ-019 In IDLE or DONE with Start=1, SHALL latch TapPtrn, Seed, SrcBase, DstBase and Length, clear the byte index and ParityErr, and go to RD, or to DONE if Length=0.
REQ-020 Start asserted in RD or WR SHALL be ignored, and input changes after latch SHALL have no effect.
REQ-021 RD SHALL drive MemAddr=SrcBase+idx (mod 256) and MemRdEn=1, then go to WR.
REQ-022 WR SHALL drive MemAddr=DstBase+idx (mod 256), MemWrEn=1 and MemWrData={1'b0, MemRdData[6:0]^state}.
REQ-023 On leaving WR, SHALL update state to {state[5:0], ^(state&TapPtrn)} and increment idx.
REQ-024 From WR, SHALL go to DONE if idx was Length-1, else to RD.
REQ-025 In WR, SHALL set ParityErr if ^MemRdData==1; ParityErr then holds until the next accepted Start or reset.
REQ-026 MemRdEn and MemWrEn SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and DONE.
REQ-027 Busy SHALL be 1 exactly in RD and WR; Ack SHALL be 1 exactly in DONE, held until a Start is accepted.
REQ-028 Throughput SHALL be 2 cycles per byte: Ack rises 2*Length+1 posedges after the posedge that accepts Start.
REQ-029 A seed of 0 SHALL be processed as-is, giving a constant 0 keystream with no special casing.
REQ-030 Address arithmetic SHALL wrap modulo 256 when a base plus index exceeds 255.

Reset
REQ-031 Reset low SHALL immediately force IDLE, with Ack, Busy, MemRdEn, MemWrEn and ParityErr at 0, and MemAddr, MemWrData, idx and state at 0.
REQ-032 Reset asserted mid-message SHALL abort it with no further memory write; operation resumes only on a new Start after reset release.

Verification
REQ-033 Tap 7'h60, Seed 7'h01, Length 1, SrcBase 8'h40 holding 8'hC9, DstBase 8'h80, Start pulse -> one write of 8'h48 to 8'h80, ParityErr=0, Ack high 3 posedges after Start accepted.
REQ-034 Length 0, Start -> no MemRdEn or MemWrEn, Ack high after 1 posedge, Busy never high.
REQ-035 Length 4, SrcBase 8'hFE, DstBase 8'hFF -> reads at FE, FF, 00, 01 and writes at FF, 00, 01, 02; Ack after 9 posedges; keystream 01, 02, 04, 08 (Tap 7'h60, Seed 7'h01).
REQ-036 Ciphertext byte 8'h49 (odd parity) -> ParityErr=1 through DONE; a new Start clears it to 0.
REQ-037 Reset pulled low during the WR of byte 2 of 5 -> outputs zero asynchronously, no write in that cycle; a fresh Start then completes all 5 bytes correctly.
REQ-038 Start held high continuously -> each DONE lasts one cycle before restarting, and Start toggling while Busy=1 has no effect on the sequence.
